// File: rtl/meteor_pkg.sv
// Shared types and default sizing for the meteor spawn scheduler.
// Optional feature macro used by the top level: DIFFICULTY_RAMP_EN.
package meteor_pkg;

  localparam int OBJ_NUM_DEF        = 4;
  localparam int SPAWN_INTERVAL_DEF = 30;
  localparam int X_MAX_DEF          = 640;
  localparam int SPEED_MIN_DEF      = 1;

  localparam int X_W   = 10;
  localparam int SPD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    OFFER = 2'd2
  } state_t;

  // Slot id is sized for the largest supported slot count (16).
  typedef struct packed {
    logic [3:0]       id;
    logic [X_W-1:0]   x;
    logic [SPD_W-1:0] x_speed;
    logic [SPD_W-1:0] y_speed;
  } spawn_cmd_t;

endpackage

// File: rtl/rr_free_slot_picker.sv
// Combinational round-robin search for the first free meteor slot,
// starting at the pointer and wrapping modulo OBJ_NUM.
module rr_free_slot_picker #(
  parameter  int OBJ_NUM = 4,
  localparam int ID_W    = $clog2(OBJ_NUM)
) (
  input  logic [OBJ_NUM-1:0] alive_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    index_o
);

  // Scan from the pointer upward; the first dead slot wins.
  always_comb begin
    int j;
    j       = 0;
    found_o = 1'b0;
    index_o = '0;
    for (int k = 0; k < OBJ_NUM; k++) begin
      j = (int'(ptr_i) + k) % OBJ_NUM;
      if (!found_o && !alive_i[j]) begin
        found_o = 1'b1;
        index_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/meteor_spawn_scheduler.sv
// Meteor spawn scheduler: counts frames, picks a free slot round-robin,
// samples and sanitises the random generator outputs, and offers one
// spawn command per interval over a valid/ready handshake.
// Optional feature macro: DIFFICULTY_RAMP_EN (shrinking interval, adds cur_interval).
module meteor_spawn_scheduler
  import meteor_pkg::*;
#(
  parameter  int OBJ_NUM        = OBJ_NUM_DEF,
  parameter  int SPAWN_INTERVAL = SPAWN_INTERVAL_DEF,
  parameter  int X_MAX          = X_MAX_DEF,
  parameter  int SPEED_MIN      = SPEED_MIN_DEF,
  localparam int ID_W           = $clog2(OBJ_NUM)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [OBJ_NUM-1:0] obj_alive,
  input  logic [9:0]         rnd_x,
  input  logic [3:0]         rnd_x_speed,
  input  logic [3:0]         rnd_y_speed,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [ID_W-1:0]    spawn_id,
  output logic [9:0]         spawn_x,
  output logic [3:0]         spawn_x_speed,
  output logic [3:0]         spawn_y_speed,
  output logic [15:0]        spawn_count
`ifdef DIFFICULTY_RAMP_EN
  ,
  output logic [7:0]         cur_interval
`endif
);

  // Fold an out-of-range x back into 0..X_MAX-1 with at most two subtractions.
  function automatic logic [9:0] sanitize_x(input logic [9:0] raw);
    int v;
    v = int'(raw);
    if (v >= X_MAX) v = v - X_MAX;
    if (v >= X_MAX) v = v - X_MAX;
    return 10'(v);
  endfunction

  // A zero speed would leave the meteor parked; substitute the minimum.
  function automatic logic [3:0] sanitize_speed(input logic [3:0] raw);
    return (raw == 4'd0) ? 4'(SPEED_MIN) : raw;
  endfunction

  // Round-robin pointer advance past the slot just spawned.
  function automatic logic [ID_W-1:0] next_ptr(input logic [3:0] id);
    return (int'(id) >= OBJ_NUM - 1) ? '0 : ID_W'(id + 4'd1);
  endfunction

  state_t             state_q;
  spawn_cmd_t         cmd_q, cmd_d;
  logic               valid_q;
  logic [15:0]        count_q;
  logic [ID_W-1:0]    rr_q;
  logic [7:0]         frame_cnt_q;
  logic               pending_q;
  logic [7:0]         eff_int;
  logic               expire;
  logic               accept;
  logic               any_dead;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  assign expire   = frame_tick && enable && (frame_cnt_q == eff_int - 8'd1);
  assign accept   = (state_q == OFFER) && spawn_ready;
  assign any_dead = |(~obj_alive);

  rr_free_slot_picker #(
    .OBJ_NUM (OBJ_NUM)
  ) u_picker (
    .alive_i (obj_alive),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

`ifdef DIFFICULTY_RAMP_EN
  localparam int         FLOOR_RAW = SPAWN_INTERVAL / 4;
  localparam logic [7:0] FLOOR     = (FLOOR_RAW < 1) ? 8'd1 : 8'(FLOOR_RAW);

  logic [7:0] target_q;
  logic [7:0] eff_q;
  logic [2:0] ramp_cnt_q;

  // Every 8 accepted spawns shorten the target interval; the counter adopts it on its next wrap.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      target_q   <= 8'(SPAWN_INTERVAL);
      eff_q      <= 8'(SPAWN_INTERVAL);
      ramp_cnt_q <= 3'd0;
    end else begin
      if (accept) begin
        ramp_cnt_q <= ramp_cnt_q + 3'd1;
        if (ramp_cnt_q == 3'd7 && target_q > FLOOR) target_q <= target_q - 8'd1;
      end
      if (expire) eff_q <= target_q;
    end
  end

  assign eff_int      = eff_q;
  assign cur_interval = target_q;
`else
  assign eff_int = 8'(SPAWN_INTERVAL);
`endif

  // Frame counter runs in every FSM state but freezes while gameplay is paused.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_tick && enable) begin
      frame_cnt_q <= expire ? 8'd0 : frame_cnt_q + 8'd1;
    end
  end

  // Pending is a single saturating flag; a new expiry beats the handshake clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pending_q <= 1'b0;
    end else if (expire) begin
      pending_q <= 1'b1;
    end else if (accept) begin
      pending_q <= 1'b0;
    end
  end

  // Sanitised command built from the picker and the current random sample.
  always_comb begin
    cmd_d         = '0;
    cmd_d.id      = 4'(pick_idx);
    cmd_d.x       = sanitize_x(rnd_x);
    cmd_d.x_speed = sanitize_speed(rnd_x_speed);
    cmd_d.y_speed = sanitize_speed(rnd_y_speed);
  end

  // Control FSM with registered command, valid and spawn counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      count_q <= 16'd0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && pending_q && any_dead) state_q <= PICK;
        end
        PICK: begin
          if (pick_found) begin
            cmd_q   <= cmd_d;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end else begin
            state_q <= IDLE;
          end
        end
        OFFER: begin
          if (spawn_ready) begin
            valid_q <= 1'b0;
            count_q <= count_q + 16'd1;
            rr_q    <= next_ptr(cmd_q.id);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spawn_valid   = valid_q;
  assign spawn_id      = cmd_q.id[ID_W-1:0];
  assign spawn_x       = cmd_q.x;
  assign spawn_x_speed = cmd_q.x_speed;
  assign spawn_y_speed = cmd_q.y_speed;
  assign spawn_count   = count_q;

endmodule
